alu_cdb_unit: RTL and testbench

//  Execution end of the RS->ALU dispatch interface: accepts one ready op per cycle from the

---
 rtl/alu_cdb_unit_pkg.sv | 45 ++++
 rtl/alu_cdb_unit_core.sv | 65 ++++++
 rtl/alu_cdb_unit.sv | 89 ++++++++
 tb/tb_alu_cdb_unit.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_cdb_unit_pkg.sv
// Shared opcodes, widths and the buffered result record for the ALU/CDB execution unit.
// Opcode numbering follows the OP_* list used by the RS and decoder.
package alu_cdb_unit_pkg;

  localparam int RLEN          = 32;
  localparam int RBID          = 4;
  localparam int ALU_BUF_DEPTH = 2;

  localparam logic [5:0] OP_LUI   = 6'd1;
  localparam logic [5:0] OP_AUIPC = 6'd2;
  localparam logic [5:0] OP_JAL   = 6'd3;
  localparam logic [5:0] OP_JALR  = 6'd4;
  localparam logic [5:0] OP_BEQ   = 6'd5;
  localparam logic [5:0] OP_BNE   = 6'd6;
  localparam logic [5:0] OP_BLT   = 6'd7;
  localparam logic [5:0] OP_BGE   = 6'd8;
  localparam logic [5:0] OP_BLTU  = 6'd9;
  localparam logic [5:0] OP_BGEU  = 6'd10;
  localparam logic [5:0] OP_ADDI  = 6'd19;
  localparam logic [5:0] OP_SLTI  = 6'd20;
  localparam logic [5:0] OP_SLTIU = 6'd21;
  localparam logic [5:0] OP_XORI  = 6'd22;
  localparam logic [5:0] OP_ORI   = 6'd23;
  localparam logic [5:0] OP_ANDI  = 6'd24;
  localparam logic [5:0] OP_SLLI  = 6'd25;
  localparam logic [5:0] OP_SRLI  = 6'd26;
  localparam logic [5:0] OP_SRAI  = 6'd27;
  localparam logic [5:0] OP_ADD   = 6'd28;
  localparam logic [5:0] OP_SUB   = 6'd29;
  localparam logic [5:0] OP_SLL   = 6'd30;
  localparam logic [5:0] OP_SLT   = 6'd31;
  localparam logic [5:0] OP_SLTU  = 6'd32;
  localparam logic [5:0] OP_XOR   = 6'd33;
  localparam logic [5:0] OP_SRL   = 6'd34;
  localparam logic [5:0] OP_SRA   = 6'd35;
  localparam logic [5:0] OP_OR    = 6'd36;
  localparam logic [5:0] OP_AND   = 6'd37;

  typedef struct packed {
    logic [RLEN-1:0] val;
    logic            jump;
    logic [RLEN-1:0] npc;
  } result_t;

endpackage

// File: rtl/alu_cdb_unit_core.sv
// Combinational integer/branch datapath: one op in, rd value plus next-PC/jump out.
// Unknown opcodes produce val=0, jump=0 so the ROB entry still completes.
module alu_cdb_unit_core
  import alu_cdb_unit_pkg::*;
(
  input  logic [5:0]      op,
  input  logic [RLEN-1:0] rs1,
  input  logic [RLEN-1:0] rs2,
  input  logic [RLEN-1:0] imm,
  input  logic [RLEN-1:0] pc,
  output result_t         res
);

  logic [4:0]      shamt;
  logic [RLEN-1:0] pc_seq;
  logic            taken;

  assign shamt  = rs2[4:0];
  assign pc_seq = pc + 32'd4;

  always_comb begin
    res.val  = '0;
    res.jump = 1'b0;
    res.npc  = pc_seq;
    taken    = 1'b0;
    case (op)
      OP_ADD, OP_ADDI:   res.val = rs1 + rs2;
      OP_SUB:            res.val = rs1 - rs2;
      OP_XOR, OP_XORI:   res.val = rs1 ^ rs2;
      OP_OR, OP_ORI:     res.val = rs1 | rs2;
      OP_AND, OP_ANDI:   res.val = rs1 & rs2;
      OP_SLL, OP_SLLI:   res.val = rs1 << shamt;
      OP_SRL, OP_SRLI:   res.val = rs1 >> shamt;
      OP_SRA, OP_SRAI:   res.val = $unsigned($signed(rs1) >>> shamt);
      OP_SLT, OP_SLTI:   res.val = {31'd0, $signed(rs1) < $signed(rs2)};
      OP_SLTU, OP_SLTIU: res.val = {31'd0, rs1 < rs2};
      OP_LUI:            res.val = imm;
      OP_AUIPC:          res.val = pc + imm;
      OP_JAL: begin
        res.val  = pc_seq;
        res.jump = 1'b1;
        res.npc  = pc + imm;
      end
      OP_JALR: begin
        res.val  = pc_seq;
        res.jump = 1'b1;
        res.npc  = (rs1 + imm) & ~32'd1;
      end
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
        case (op)
          OP_BEQ:  taken = (rs1 == rs2);
          OP_BNE:  taken = (rs1 != rs2);
          OP_BLT:  taken = ($signed(rs1) < $signed(rs2));
          OP_BGE:  taken = ($signed(rs1) >= $signed(rs2));
          OP_BLTU: taken = (rs1 < rs2);
          default: taken = (rs1 >= rs2);
        endcase
        res.jump = taken;
        res.npc  = taken ? (pc + imm) : pc_seq;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_cdb_unit.sv
// ALU execution unit: accepts RS ops, buffers results in a small FIFO and broadcasts the
// head on the CDB under arbiter grant. Rollback flushes the buffer; rdy_in low freezes it.
module alu_cdb_unit
  import alu_cdb_unit_pkg::*;
#(
  parameter int BUF_DEPTH   = ALU_BUF_DEPTH,
  parameter int TAG_W       = RBID,
  parameter bit CHECK_ISSUE = 1'b1
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             rdy_in,
  input  logic             rollback_in,
  input  logic             flag_alu,
  input  logic [5:0]       op_alu,
  input  logic [31:0]      rs1_alu,
  input  logic [31:0]      rs2_alu,
  input  logic [31:0]      imm_alu,
  input  logic [31:0]      pc_alu,
  input  logic [TAG_W-1:0] rob_alu,
  output logic             alu_ready,
  input  logic             cdb_grant_in,
  output logic             cdb_valid,
  output logic [TAG_W-1:0] cdb_rob,
  output logic [31:0]      cdb_val,
  output logic             cdb_jump,
  output logic [31:0]      cdb_pc
);

  localparam int               PTR_W   = $clog2(BUF_DEPTH);
  localparam logic [PTR_W:0]   DEPTH_C = BUF_DEPTH[PTR_W:0];

  result_t          core_res;
  result_t          res_q [BUF_DEPTH];
  logic [TAG_W-1:0] tag_q [BUF_DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [PTR_W:0]   count;
  logic             push, pop, non_empty;

  alu_cdb_unit_core u_core (
    .op  (op_alu),
    .rs1 (rs1_alu),
    .rs2 (rs2_alu),
    .imm (imm_alu),
    .pc  (pc_alu),
    .res (core_res)
  );

  assign non_empty = (count != '0);
  assign alu_ready = rdy_in & (count < DEPTH_C);
  assign cdb_valid = rdy_in & non_empty;
  assign push      = flag_alu & alu_ready & ~rollback_in;
  assign pop       = cdb_valid & cdb_grant_in & ~rollback_in;

  // Head fields read as zero when empty so stale entries never leak onto the bus.
  assign cdb_rob  = non_empty ? tag_q[rd_ptr]      : '0;
  assign cdb_val  = non_empty ? res_q[rd_ptr].val  : '0;
  assign cdb_jump = non_empty ? res_q[rd_ptr].jump : 1'b0;
  assign cdb_pc   = non_empty ? res_q[rd_ptr].npc  : '0;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (rollback_in) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + (PTR_W+1)'(1);
      else if (!push && pop) count <= count - (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (push) begin
      res_q[wr_ptr] <= core_res;
      tag_q[wr_ptr] <= rob_alu;
    end
  end

  // The RS is expected to hold off while the unit is full.
  assert property (@(posedge clk_in) disable iff (!rst_n_in)
    !(CHECK_ISSUE && flag_alu && rdy_in && !rollback_in && !alu_ready));

endmodule

// File: tb/tb_alu_cdb_unit.sv
// Directed bench for alu_cdb_unit: queue-based reference model checked every cycle,
// plus literal expectations for the key operations and handshake corner cases.
module tb_alu_cdb_unit;
  import alu_cdb_unit_pkg::*;

  logic        clk = 1'b0, rst_n = 1'b1, rdy = 1'b1, rb = 1'b0, flag = 1'b0, grant = 1'b0;
  logic [5:0]  op = '0;
  logic [31:0] rs1 = '0, rs2 = '0, imm = '0, pc = '0;
  logic [3:0]  tag = '0;
  logic        alu_ready, cdb_valid, cdb_jump;
  logic [3:0]  cdb_rob;
  logic [31:0] cdb_val, cdb_pc;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  alu_cdb_unit #(.BUF_DEPTH(2), .TAG_W(4), .CHECK_ISSUE(1'b0)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .rdy_in(rdy), .rollback_in(rb),
    .flag_alu(flag), .op_alu(op), .rs1_alu(rs1), .rs2_alu(rs2), .imm_alu(imm),
    .pc_alu(pc), .rob_alu(tag), .alu_ready(alu_ready), .cdb_grant_in(grant),
    .cdb_valid(cdb_valid), .cdb_rob(cdb_rob), .cdb_val(cdb_val),
    .cdb_jump(cdb_jump), .cdb_pc(cdb_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  tag;
    logic [31:0] val;
    logic        jump;
    logic [31:0] npc;
  } ent_t;
  ent_t q[$];

  function automatic ent_t model(logic [5:0] o, logic [31:0] a, logic [31:0] b,
                                 logic [31:0] i, logic [31:0] p, logic [3:0] t);
    ent_t e;
    longint sa, sb;
    int    sh;
    bit    c;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = int'(b % 32);
    e.tag = t; e.val = 32'd0; e.jump = 1'b0; e.npc = p + 32'd4;
    c = 1'b0;
    case (o)
      OP_ADD, OP_ADDI:   e.val = 32'(sa + sb);
      OP_SUB:            e.val = 32'(sa - sb);
      OP_XOR, OP_XORI:   e.val = a ^ b;
      OP_OR, OP_ORI:     e.val = a | b;
      OP_AND, OP_ANDI:   e.val = a & b;
      OP_SLL, OP_SLLI:   e.val = 32'(longint'(a) * (longint'(1) << sh));
      OP_SRL, OP_SRLI:   e.val = 32'(longint'(a) / (longint'(1) << sh));
      OP_SRA, OP_SRAI:   e.val = 32'(sa >>> sh);
      OP_SLT, OP_SLTI:   e.val = (sa < sb) ? 32'd1 : 32'd0;
      OP_SLTU, OP_SLTIU: e.val = (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
      OP_LUI:            e.val = i;
      OP_AUIPC:          e.val = p + i;
      OP_JAL:  begin e.val = p + 32'd4; e.jump = 1'b1; e.npc = p + i; end
      OP_JALR: begin e.val = p + 32'd4; e.jump = 1'b1; e.npc = {31'(32'(a + i) >> 1), 1'b0}; end
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
        if (o == OP_BEQ)  c = (a == b);
        if (o == OP_BNE)  c = (a != b);
        if (o == OP_BLT)  c = (sa < sb);
        if (o == OP_BGE)  c = !(sa < sb);
        if (o == OP_BLTU) c = (longint'(a) < longint'(b));
        if (o == OP_BGEU) c = !(longint'(a) < longint'(b));
        e.jump = c;
        if (c) e.npc = p + i;
      end
      default: ;
    endcase
    return e;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) q.delete();
    else if (rb) q.delete();
    else if (rdy) begin : upd
      bit do_pop, do_push;
      do_pop  = grant && (q.size() != 0);
      do_push = flag && (q.size() < 2);
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(model(op, rs1, rs2, imm, pc, tag));
    end
  end

  always @(negedge clk) begin
    if (cmp_en && rst_n) begin
      chk("m_valid", {31'd0, cdb_valid}, {31'd0, rdy && (q.size() != 0)});
      chk("m_ready", {31'd0, alu_ready}, {31'd0, rdy && (q.size() < 2)});
      if (cdb_valid && q.size() != 0) begin
        chk("m_rob",  {28'd0, cdb_rob}, {28'd0, q[0].tag});
        chk("m_val",  cdb_val, q[0].val);
        chk("m_jump", {31'd0, cdb_jump}, {31'd0, q[0].jump});
        chk("m_pc",   cdb_pc, q[0].npc);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(logic [5:0] o, logic [31:0] a, logic [31:0] b,
                       logic [31:0] i, logic [31:0] p, logic [3:0] t);
    flag = 1'b1; op = o; rs1 = a; rs2 = b; imm = i; pc = p; tag = t;
  endtask

  typedef struct {
    logic [5:0]  o;
    logic [31:0] a, b, i, p;
  } vec_t;
  vec_t vecs[12];

  initial begin
    vecs[0]  = '{OP_ADDI,  32'hFFFF_FFFF, 32'd1,        32'd0,        32'h500};
    vecs[1]  = '{OP_SLT,   32'hFFFF_FFF0, 32'd3,        32'd0,        32'h504};
    vecs[2]  = '{OP_SLTU,  32'hFFFF_FFF0, 32'd3,        32'd0,        32'h508};
    vecs[3]  = '{OP_SLL,   32'h0000_0003, 32'h0000_0021, 32'd0,       32'h50C};
    vecs[4]  = '{OP_SRL,   32'h8000_0000, 32'd31,       32'd0,        32'h510};
    vecs[5]  = '{OP_AND,   32'hF0F0_1234, 32'h0FF0_FFFF, 32'd0,       32'h514};
    vecs[6]  = '{OP_AUIPC, 32'd0,         32'd0,        32'h0000_1000, 32'h518};
    vecs[7]  = '{OP_JAL,   32'd0,         32'd0,        32'hFFFF_FFF0, 32'h51C};
    vecs[8]  = '{OP_BEQ,   32'd9,         32'd9,        32'h40,       32'h520};
    vecs[9]  = '{OP_BNE,   32'd9,         32'd9,        32'h40,       32'h524};
    vecs[10] = '{OP_BGEU,  32'hFFFF_FFFF, 32'd1,        32'h80,       32'h528};
    vecs[11] = '{6'd63,    32'd5,         32'd6,        32'd7,        32'h52C};

    #1 rst_n = 1'b0;
    step(); step();
    chk("rst_valid", {31'd0, cdb_valid}, 32'd0);
    chk("rst_ready", {31'd0, alu_ready}, 32'd1);
    chk("rst_rob",   {28'd0, cdb_rob}, 32'd0);
    chk("rst_val",   cdb_val, 32'd0);
    chk("rst_pc",    cdb_pc, 32'd0);
    chk("rst_jump",  {31'd0, cdb_jump}, 32'd0);
    rst_n = 1'b1; cmp_en = 1'b1;
    step();

    // ADD with grant held: latency one cycle, then popped
    grant = 1'b1;
    drive(OP_ADD, 32'd5, 32'd7, 32'd0, 32'h200, 4'd3); step(); flag = 1'b0;
    chk("add_valid", {31'd0, cdb_valid}, 32'd1);
    chk("add_rob",   {28'd0, cdb_rob}, 32'd3);
    chk("add_val",   cdb_val, 32'd12);
    chk("add_jump",  {31'd0, cdb_jump}, 32'd0);
    chk("add_pc",    cdb_pc, 32'h204);
    step();
    chk("add_popped", {31'd0, cdb_valid}, 32'd0);

    // Fill with grant low; third op dropped; drain in order
    grant = 1'b0;
    drive(OP_SUB, 32'd10, 32'd3, 32'd0, 32'h300, 4'd1); step();
    chk("fill1_ready", {31'd0, alu_ready}, 32'd1);
    drive(OP_XOR, 32'hF0F0, 32'h0FF0, 32'd0, 32'h304, 4'd2); step();
    chk("full_ready", {31'd0, alu_ready}, 32'd0);
    drive(OP_OR, 32'd1, 32'd2, 32'd0, 32'h308, 4'd3); step(); flag = 1'b0;
    chk("head_rob", {28'd0, cdb_rob}, 32'd1);
    chk("head_val", cdb_val, 32'd7);
    grant = 1'b1; step();
    chk("second_rob",   {28'd0, cdb_rob}, 32'd2);
    chk("second_val",   cdb_val, 32'h0000_FF00);
    chk("pop_ready",    {31'd0, alu_ready}, 32'd1);
    step();
    chk("drained", {31'd0, cdb_valid}, 32'd0);

    // Branch / jump / shift literals
    drive(OP_BLT, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 4'd4); step();
    chk("blt_jump", {31'd0, cdb_jump}, 32'd1);
    chk("blt_pc",   cdb_pc, 32'h120);
    chk("blt_val",  cdb_val, 32'd0);
    drive(OP_BLTU, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 4'd5); step();
    chk("bltu_jump", {31'd0, cdb_jump}, 32'd0);
    chk("bltu_pc",   cdb_pc, 32'h104);
    drive(OP_JALR, 32'h1003, 32'd0, 32'd0, 32'h40, 4'd6); step();
    chk("jalr_val",  cdb_val, 32'h44);
    chk("jalr_pc",   cdb_pc, 32'h1002);
    chk("jalr_jump", {31'd0, cdb_jump}, 32'd1);
    drive(OP_SRA, 32'h8000_0000, 32'h24, 32'd0, 32'h44, 4'd7); step();
    chk("sra_val", cdb_val, 32'hF800_0000);
    flag = 1'b0; step();

    // Model-only sweep over remaining ops, alternating grant to mix push/pop patterns
    for (int k = 0; k < 12; k++) begin
      grant = (k % 3) != 2;
      drive(vecs[k].o, vecs[k].a, vecs[k].b, vecs[k].i, vecs[k].p, 4'(k));
      if (alu_ready) step(); else begin flag = 1'b0; step(); end
    end
    flag = 1'b0; grant = 1'b1; step(); step(); step();

    // Rollback with two buffered and a same-cycle issue
    grant = 1'b0;
    drive(OP_ADD, 32'd1, 32'd1, 32'd0, 32'h600, 4'd8); step();
    drive(OP_ADD, 32'd2, 32'd2, 32'd0, 32'h604, 4'd9); step();
    drive(OP_ADD, 32'd3, 32'd3, 32'd0, 32'h608, 4'd10); rb = 1'b1; step();
    rb = 1'b0; flag = 1'b0;
    chk("rb_valid", {31'd0, cdb_valid}, 32'd0);
    chk("rb_ready", {31'd0, alu_ready}, 32'd1);
    grant = 1'b1; step();
    chk("rb_nothing", {31'd0, cdb_valid}, 32'd0);

    // rdy_in low with grant high: frozen, head kept
    grant = 1'b0;
    drive(OP_LUI, 32'd0, 32'd0, 32'h1234_5000, 32'h700, 4'd5); step(); flag = 1'b0;
    rdy = 1'b0; grant = 1'b1; step(); step();
    chk("frz_valid", {31'd0, cdb_valid}, 32'd0);
    chk("frz_ready", {31'd0, alu_ready}, 32'd0);
    chk("frz_rob",   {28'd0, cdb_rob}, 32'd5);
    chk("frz_val",   cdb_val, 32'h1234_5000);
    rdy = 1'b1; #1;
    chk("thaw_valid", {31'd0, cdb_valid}, 32'd1);
    step();
    chk("thaw_popped", {31'd0, cdb_valid}, 32'd0);

    // Reset mid-traffic with two entries buffered
    grant = 1'b0;
    drive(OP_ADD, 32'd4, 32'd4, 32'd0, 32'h800, 4'd11); step();
    drive(OP_ADD, 32'd5, 32'd5, 32'd0, 32'h804, 4'd12); step(); flag = 1'b0;
    chk("pre_rst_valid", {31'd0, cdb_valid}, 32'd1);
    rst_n = 1'b0; #1;
    chk("mid_rst_valid", {31'd0, cdb_valid}, 32'd0);
    chk("mid_rst_ready", {31'd0, alu_ready}, 32'd1);
    step(); rst_n = 1'b1; step();
    chk("post_rst_valid", {31'd0, cdb_valid}, 32'd0);
    chk("post_rst_ready", {31'd0, alu_ready}, 32'd1);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
